sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Parametrised single-clock synchronous FIFO. It is the next generation of the processor's instruction/data staging FIFO.
- All activity is on the rising edge of clk. The previous split posedge-write / negedge-read scheme is removed.
- Adds a true occupancy counter, correct wrap at non-power-of-two depths, programmable almost-full/almost-empty thresholds and a registered read-valid strobe.
- Sits between the fetch/decode stages and the execution queue. Any producer/consumer pair in the processor can reuse it.

Parameters:
- WORD_SIZE, 54, data width in bits.
- FIFO_DEPTH, 21, number of storage entries; any value >= 2, power of two not required.
- AF_THRESH, FIFO_DEPTH-2, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH.
- CNT_W, $clog2(FIFO_DEPTH+1), width of the count output (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- write_enable  input  1  push request.
- read_enable  input  1  pop request.
- data_in  input  WORD_SIZE  push data.
- data_out  output  WORD_SIZE  popped word, registered.
- data_valid  output  1  one-cycle strobe; data_out holds a popped word.
- empty_signal  output  1  count == 0.
- full_signal  output  1  count == FIFO_DEPTH.
- almost_empty  output  1  count <= AE_THRESH.
- almost_full  output  1  count >= AF_THRESH.
- count  output  CNT_W  current occupancy.

Behaviour:
- Reset (reset==0 at a clk edge):
  - Pointers wrptr/rdptr = 0, count = 0.
  - data_out = 0, data_valid = 0.
  - empty_signal = 1, full_signal = 0, almost_empty = 1, almost_full = (AF_THRESH==0).
  - Storage array is not cleared.
  - Reset overrides any simultaneous read/write. Reset mid-stream discards all contents.
- Acceptance rules:
  - wr_ok = write_enable & (!full_signal | rd_ok).
  - rd_ok = read_enable & !empty_signal.
- Write: on wr_ok, mem[wrptr] <= data_in.
- Read latency 1 cycle. On rd_ok, data_out <= mem[rdptr] and data_valid <= 1 at the same edge; otherwise data_valid <= 0 and data_out holds its last value.
- Pointer wrap: a pointer equal to FIFO_DEPTH-1 advances to 0, otherwise +1. Pointers never index beyond FIFO_DEPTH-1.
- count update:
  - wr_ok only: +1.
  - rd_ok only: -1.
  - both or neither: unchanged.
- All four flags are registered, computed from next-count, so they are valid in the same cycle count is.
- Boundary cases:
  - Write while full with no read: dropped, no state change.
  - Read while empty: ignored; data_valid stays 0. There is no write-through bypass, so simultaneous read+write on empty accepts only the write.
  - Simultaneous read+write while full: both accepted, count stays FIFO_DEPTH, data ordering preserved.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: SYNC_FIFO_ERR_FLAGS_EN.
- When defined, the block adds:
  - Input err_clear (1 bit).
  - Sticky outputs overflow and underflow (1 bit each).
- Setting rules:
  - overflow sets on write_enable & full_signal & !rd_ok.
  - underflow sets on read_enable & empty_signal.
- Both clear on reset or on err_clear==1. If set and clear occur in the same cycle, set wins.
- When not defined, these ports and logic do not exist. Dropped and ignored requests are silent.

Decomposition:
- Package sync_fifo_pkg holds:
  - Default WORD_SIZE/FIFO_DEPTH constants.
  - Function next_ptr(ptr, depth) implementing the wrap rule.
  - Typedef for the processor's 54-bit FIFO word.
- One sub-module, fifo_ptr_ctr: parametrised wrapping pointer with enable and synchronous active-low reset. It is instantiated twice (write and read pointers).

Test Plan:
- Reset hold then release, no traffic -> empty_signal=1, full_signal=0, count=0, almost_empty=1, data_valid=0.
- Push 21 words 1..21 (default depth) -> count reaches 21, full_signal=1 and almost_full=1 from count=19; 22nd push dropped (overflow=1 with SYNC_FIFO_ERR_FLAGS_EN).
- Pop all 21 words -> each data_out appears 1 cycle after its read, values 1..21 in order, data_valid high each time; empty_signal=1 after the last pop. An extra pop leaves data_valid=0 (underflow=1 with the macro).
- Fill to full, then simultaneous read+write of 100 for 10 cycles -> count stays 21, output order continuous. Run 50 mixed random-occupancy cycles -> pointers wrap past index 20 with no corruption, checked against a scoreboard.
- Load 5 words, assert reset low for one cycle -> count=0, empty_signal=1. Next push of 77 then pop yields data_out=77.
- Empty FIFO, simultaneous read+write of 42 -> read ignored, count=1, data_valid=0. Next-cycle read -> data_out=42, data_valid=1.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_fifo_pkg : shared constants, word type and pointer-wrap helper      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package sync_fifo_pkg;

  localparam int unsigned DEF_WORD_SIZE  = 54;
  localparam int unsigned DEF_FIFO_DEPTH = 21;

  typedef logic [DEF_WORD_SIZE-1:0] fifo_word_t;

  // Wraps at depth-1 so non-power-of-two depths never index past the array.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ptr_ctr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_ptr_ctr : wrapping FIFO pointer with enable, sync active-low reset  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fifo_ptr_ctr
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEF_FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = PTR_W'(next_ptr(32'(ptr_q), DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_fifo_param : single-clock FIFO, occupancy count, threshold flags,   |
// | registered read. SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = DEF_WORD_SIZE,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned AF_THRESH  = FIFO_DEPTH - 2,
  parameter int unsigned AE_THRESH  = 2,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write_enable,
  input  logic                 read_enable,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 data_valid,
  output logic                 empty_signal,
  output logic                 full_signal,
  output logic                 almost_empty,
  output logic                 almost_full,
  output logic [CNT_W-1:0]     count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  input  logic                 err_clear,
  output logic                 overflow,
  output logic                 underflow
`endif
);

  localparam int unsigned      PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] C_AF    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] C_AE    = CNT_W'(AE_THRESH);

  logic [WORD_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wrptr;
  logic [PTR_W-1:0]     rdptr;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     count_d;
  logic [WORD_SIZE-1:0] dout_q;
  logic                 valid_q;
  logic                 empty_q;
  logic                 full_q;
  logic                 ae_q;
  logic                 af_q;
  logic                 rd_ok;
  logic                 wr_ok;

  // A full FIFO still accepts a write when the same cycle frees a slot.
  assign rd_ok = read_enable & ~empty_q;
  assign wr_ok = write_enable & (~full_q | rd_ok);

  fifo_ptr_ctr #(.DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .en_i  (wr_ok),
    .ptr_o (wrptr)
  );

  fifo_ptr_ctr #(.DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .en_i  (rd_ok),
    .ptr_o (rdptr)
  );

  always_comb begin
    count_d = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + 1'b1;
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && wr_ok) begin
      mem_q[wrptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ae_q    <= 1'b1;
      af_q    <= (AF_THRESH == 0);
    end else begin
      count_q <= count_d;
      valid_q <= rd_ok;
      if (rd_ok) begin
        dout_q <= mem_q[rdptr];
      end
      // Flags track next-count so they line up with the registered count.
      empty_q <= (count_d == '0);
      full_q  <= (count_d == C_DEPTH);
      ae_q    <= (count_d <= C_AE);
      af_q    <= (count_d >= C_AF);
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_q;
  logic unf_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (write_enable && full_q && !rd_ok) begin
        ovf_q <= 1'b1;
      end else if (err_clear) begin
        ovf_q <= 1'b0;
      end
      if (read_enable && empty_q) begin
        unf_q <= 1'b1;
      end else if (err_clear) begin
        unf_q <= 1'b0;
      end
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`endif

  assign data_out     = dout_q;
  assign data_valid   = valid_q;
  assign empty_signal = empty_q;
  assign full_signal  = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign count        = count_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sync_fifo_param : directed self-checking bench for sync_fifo_param    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_sync_fifo_param;

  localparam int WS = 54;
  localparam int D  = 21;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          write_enable = 1'b0;
  logic          read_enable = 1'b0;
  logic [WS-1:0] data_in = '0;
  logic [WS-1:0] data_out;
  logic          data_valid;
  logic          empty_signal;
  logic          full_signal;
  logic          almost_empty;
  logic          almost_full;
  logic [CW-1:0] count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic          err_clear = 1'b0;
  logic          overflow;
  logic          underflow;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [WS-1:0] m_q[$];
  logic [WS-1:0] m_dout = '0;
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_param dut (
    .clk          (clk),
    .reset        (reset),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .data_in      (data_in),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .empty_signal (empty_signal),
    .full_signal  (full_signal),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    .err_clear    (err_clear),
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of traffic; the queue model predicts every output after the edge.
  task automatic xfer(input logic we, input logic re, input logic [WS-1:0] din);
    int  sz;
    logic rok, wok;
    sz  = m_q.size();
    rok = re && (sz != 0);
    wok = we && ((sz != D) || rok);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    if (we && (sz == D) && !rok) m_ovf = 1'b1;
    else if (err_clear)          m_ovf = 1'b0;
    if (re && (sz == 0))         m_unf = 1'b1;
    else if (err_clear)          m_unf = 1'b0;
`endif
    if (rok) m_dout = m_q.pop_front();
    if (wok) m_q.push_back(din);
    write_enable = we;
    read_enable  = re;
    data_in      = din;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    sz = m_q.size();
    chk("count", 64'(count), 64'(sz));
    chk("data_valid", 64'(data_valid), 64'(rok));
    chk("data_out", 64'(data_out), 64'(m_dout));
    chk("empty", 64'(empty_signal), 64'(sz == 0));
    chk("full", 64'(full_signal), 64'(sz == D));
    chk("almost_empty", 64'(almost_empty), 64'(sz <= 2));
    chk("almost_full", 64'(almost_full), 64'(sz >= D - 2));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("underflow", 64'(underflow), 64'(m_unf));
`endif
  endtask

  task automatic do_reset(input logic we, input logic re);
    reset        = 1'b0;
    write_enable = we;
    read_enable  = re;
    data_in      = WS'(64'hDEAD);
    @(posedge clk);
    #1;
    reset        = 1'b1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    m_q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  initial begin
    // Reset hold then release, idle
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    xfer(1'b0, 1'b0, '0);
    chk("rst_empty", 64'(empty_signal), 64'd1);
    chk("rst_full", 64'(full_signal), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ae", 64'(almost_empty), 64'd1);
    chk("rst_af", 64'(almost_full), 64'd0);
    chk("rst_dv", 64'(data_valid), 64'd0);
    chk("rst_dout", 64'(data_out), 64'd0);

    // Push 1..21, then a dropped 22nd
    for (int i = 1; i <= D; i++) begin
      xfer(1'b1, 1'b0, WS'(i));
      chk("push_count", 64'(count), 64'(i));
      chk("push_af", 64'(almost_full), 64'(i >= 19));
    end
    chk("full_after_21", 64'(full_signal), 64'd1);
    xfer(1'b1, 1'b0, WS'(64'd99));
    chk("drop_count", 64'(count), 64'd21);
    chk("drop_full", 64'(full_signal), 64'd1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("ovf_set", 64'(overflow), 64'd1);
    err_clear = 1'b1;
    xfer(1'b0, 1'b0, '0);
    err_clear = 1'b0;
    chk("ovf_cleared", 64'(overflow), 64'd0);
`endif

    // Pop all 21 in order, then one extra pop
    for (int i = 1; i <= D; i++) begin
      xfer(1'b0, 1'b1, '0);
      chk("pop_data", 64'(data_out), 64'(i));
      chk("pop_dv", 64'(data_valid), 64'd1);
    end
    chk("empty_after_pop", 64'(empty_signal), 64'd1);
    xfer(1'b0, 1'b1, '0);
    chk("extra_pop_dv", 64'(data_valid), 64'd0);
    chk("extra_pop_hold", 64'(data_out), 64'd21);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("unf_set", 64'(underflow), 64'd1);
`endif

    // Fill with 101..121, then 10 read+write cycles writing 100
    for (int i = 0; i < D; i++) xfer(1'b1, 1'b0, WS'(101 + i));
    for (int i = 0; i < 10; i++) begin
      xfer(1'b1, 1'b1, WS'(64'd100));
      chk("rw_full_data", 64'(data_out), 64'(101 + i));
      chk("rw_full_count", 64'(count), 64'd21);
    end

    // Mixed traffic wrapping both pointers, then drain against the model
    for (int i = 0; i < 50; i++) begin
      xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), WS'({$urandom, $urandom}));
    end
    for (int i = 0; i <= D; i++) xfer(1'b0, 1'b1, '0);
    chk("drained_empty", 64'(empty_signal), 64'd1);

    // Mid-stream reset discards contents
    for (int i = 0; i < 5; i++) xfer(1'b1, 1'b0, WS'(11 + i));
    do_reset(1'b1, 1'b1);
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_empty", 64'(empty_signal), 64'd1);
    chk("midrst_dout", 64'(data_out), 64'd0);
    chk("midrst_dv", 64'(data_valid), 64'd0);
    xfer(1'b1, 1'b0, WS'(64'd77));
    xfer(1'b0, 1'b1, '0);
    chk("after_rst_data", 64'(data_out), 64'd77);
    chk("after_rst_dv", 64'(data_valid), 64'd1);

    // Read+write on empty: only the write lands
    xfer(1'b1, 1'b1, WS'(64'd42));
    chk("rw_empty_count", 64'(count), 64'd1);
    chk("rw_empty_dv", 64'(data_valid), 64'd0);
    xfer(1'b0, 1'b1, '0);
    chk("rw_empty_data", 64'(data_out), 64'd42);
    chk("rw_empty_dv2", 64'(data_valid), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
